wb_stage_param: RTL and testbench

//  Parametrised write-back stage for the pipelined ARM datapath, sitting between memory stage and register file.

---
 rtl/wb_stage_param.sv | 104 ++++++++++
 tb/tb_wb_stage_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// Write-back stage: picks one of NSRC results, registers it with rd/PC/write-enable
// behind a valid/ready handshake, and counts retired instructions. Optional macro WB_LOAD_EXT_EN.
module wb_stage_param #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int NSRC       = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      iw_clk,
  input  logic                      iw_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic [NSRC*DATA_W-1:0]    src_data,
  input  logic [$clog2(NSRC)-1:0]   src_sel,
  input  logic [REG_ADDR_W-1:0]     rd_in,
  input  logic                      reg_write_in,
  input  logic [DATA_W-1:0]         pc_in,
`ifdef WB_LOAD_EXT_EN
  input  logic [1:0]                ld_size,
  input  logic                      ld_signed,
  input  logic [1:0]                addr_lo,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         write_data,
  output logic [REG_ADDR_W-1:0]     rd_out,
  output logic                      reg_write_out,
  output logic [DATA_W-1:0]         pc_out,
  output logic [CNT_W-1:0]          retire_cnt
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high.
  // in_ready ignores flush; flush only suppresses the accept and kills the held entry.
  logic              accept;
  logic              retire;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] mem_data;
  logic              reg_write_q;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;
  assign retire   = out_valid & out_ready & !flush;

`ifdef WB_LOAD_EXT_EN
  logic [DATA_W-1:0] mem_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign mem_word = src_data[DATA_W +: DATA_W];
  assign ld_byte  = mem_word[{addr_lo, 3'b000} +: 8];
  assign ld_half  = mem_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    mem_data = mem_word;
    case (ld_size)
      2'b00:   mem_data = {{(DATA_W-8){ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   mem_data = {{(DATA_W-16){ld_signed & ld_half[15]}}, ld_half};
      default: mem_data = mem_word;
    endcase
  end
`else
  assign mem_data = src_data[DATA_W +: DATA_W];
`endif

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(src_sel) == k) begin
        sel_data = (k == 1) ? mem_data : src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      out_valid   <= 1'b0;
      write_data  <= '0;
      rd_out      <= '0;
      pc_out      <= '0;
      reg_write_q <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        write_data  <= sel_data;
        rd_out      <= rd_in;
        pc_out      <= pc_in;
        reg_write_q <= reg_write_in;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      if (retire) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
    end
  end

  assign reg_write_out = out_valid & reg_write_q;

endmodule

// File: tb/tb_wb_stage_param.sv
// Directed bench for wb_stage_param: a default instance plus an NSRC=3/CNT_W=4
// instance sharing the same stimulus (out-of-range select and counter wrap).
module tb_wb_stage_param;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         flush;
  logic [127:0] src_data;
  logic [1:0]   src_sel;
  logic [3:0]   rd_in;
  logic         reg_write_in;
  logic [31:0]  pc_in;
  logic [1:0]   ld_size;
  logic         ld_signed;
  logic [1:0]   addr_lo;
  logic         out_ready;

  logic         in_ready, out_valid, reg_write_out;
  logic [31:0]  write_data, pc_out;
  logic [3:0]   rd_out;
  logic [15:0]  retire_cnt;

  logic         in_ready2, out_valid2, reg_write_out2;
  logic [31:0]  write_data2, pc_out2;
  logic [3:0]   rd_out2;
  logic [3:0]   retire_cnt2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  wb_stage_param dut (
    .iw_clk(clk), .iw_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .src_data(src_data), .src_sel(src_sel), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .pc_in(pc_in),
`ifdef WB_LOAD_EXT_EN
    .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr_lo),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .write_data(write_data),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .pc_out(pc_out),
    .retire_cnt(retire_cnt)
  );

  wb_stage_param #(.NSRC(3), .CNT_W(4)) dut2 (
    .iw_clk(clk), .iw_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .flush(flush), .src_data(src_data[95:0]), .src_sel(src_sel), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .pc_in(pc_in),
`ifdef WB_LOAD_EXT_EN
    .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr_lo),
`endif
    .out_valid(out_valid2), .out_ready(out_ready), .write_data(write_data2),
    .rd_out(rd_out2), .reg_write_out(reg_write_out2), .pc_out(pc_out2),
    .retire_cnt(retire_cnt2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: every source slot gets a distinct non-zero filler, then the selected one is overwritten
  task automatic drive(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] rd,
                       input logic [31:0] pc, input logic rw);
    in_valid     = 1'b1;
    src_data     = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    src_data[int'(sel)*32 +: 32] = data;
    src_sel      = sel;
    rd_in        = rd;
    pc_in        = pc;
    reg_write_in = rw;
  endtask

  task automatic drive_load(input logic [1:0] size, input logic sgn, input logic [1:0] lo);
    drive(2'd1, 32'h8000_FF7F, 4'd2, 32'h400, 1'b1);
    ld_size   = size;
    ld_signed = sgn;
    addr_lo   = lo;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; src_data = '0; src_sel = '0;
    rd_in = '0; reg_write_in = 1'b0; pc_in = '0; ld_size = '0; ld_signed = 1'b0;
    addr_lo = '0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_rd_out", {28'b0, rd_out}, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_reg_write", {31'b0, reg_write_out}, 32'd0);
    check("rst_retire_cnt", {16'b0, retire_cnt}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // back-to-back ALU results 1,2,3
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(2'd0, i, i[3:0], 32'h100 + 4 * i, 1'b1);
      exp_q.push_back(i);
      step();
      exp_v = exp_q.pop_front();
      check("b2b_valid", {31'b0, out_valid}, 32'd1);
      check("b2b_data", write_data, exp_v);
      check("b2b_rd", {28'b0, rd_out}, exp_v);
      check("b2b_pc", pc_out, 32'h100 + 4 * exp_v);
    end
    in_valid = 1'b0;
    step();
    check("b2b_drained", {31'b0, out_valid}, 32'd0);
    check("b2b_retire", {16'b0, retire_cnt}, 32'd3);

    // stall: link result held while the next instruction waits
    out_ready = 1'b0;
    drive(2'd2, 32'h200, 4'd7, 32'h1FC, 1'b1);
    step();
    drive(2'd3, 32'hABCD, 4'd9, 32'h300, 1'b0);
    for (int c = 0; c < 4; c++) begin
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_data", write_data, 32'h200);
      check("stall_rd", {28'b0, rd_out}, 32'd7);
      check("stall_pc", pc_out, 32'h1FC);
      check("stall_rw", {31'b0, reg_write_out}, 32'd1);
      step();
    end
    check("stall_retire", {16'b0, retire_cnt}, 32'd3);
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("unstall_data", write_data, 32'hABCD);
    check("unstall_rd", {28'b0, rd_out}, 32'd9);
    check("unstall_rw_off", {31'b0, reg_write_out}, 32'd0);
    check("sel_oob_zero", write_data2, 32'd0);
    check("unstall_retire", {16'b0, retire_cnt}, 32'd4);

    // flush kills held entry and discards the incoming one, no retire
    drive(2'd0, 32'h55, 4'd5, 32'h500, 1'b1);
    step();
    check("preflush_rd", {28'b0, rd_out}, 32'd5);
    check("preflush_rw", {31'b0, reg_write_out}, 32'd1);
    check("preflush_retire", {16'b0, retire_cnt}, 32'd5);
    drive(2'd0, 32'h66, 4'd6, 32'h504, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_rw", {31'b0, reg_write_out}, 32'd0);
    check("flush_retire", {16'b0, retire_cnt}, 32'd5);
    step();
    check("flush_discard", {31'b0, out_valid}, 32'd0);

    // memory source: extracted when the load unit is built in, raw otherwise
    drive_load(2'b00, 1'b1, 2'd0);
    step();
`ifdef WB_LOAD_EXT_EN
    check("ld_byte0_s", write_data, 32'h0000_007F);
`else
    check("mem_raw0", write_data, 32'h8000_FF7F);
`endif
    drive_load(2'b00, 1'b1, 2'd1);
    step();
`ifdef WB_LOAD_EXT_EN
    check("ld_byte1_s", write_data, 32'hFFFF_FFFF);
`else
    check("mem_raw1", write_data, 32'h8000_FF7F);
`endif
    drive_load(2'b01, 1'b0, 2'd2);
    step();
`ifdef WB_LOAD_EXT_EN
    check("ld_half2_u", write_data, 32'h0000_8000);
`else
    check("mem_raw2", write_data, 32'h8000_FF7F);
`endif
    in_valid = 1'b0;
    step();
    check("ld_retire", {16'b0, retire_cnt}, 32'd8);

    // nine more retirements: 17 total, the 4-bit counter wraps to 1
    for (int i = 0; i < 9; i++) begin
      drive(2'd0, 32'h1000 + i, 4'd1, 32'h600, 1'b1);
      exp_q.push_back(32'h1000 + i);
      step();
      exp_v = exp_q.pop_front();
      check("wrap_data", write_data, exp_v);
    end
    in_valid = 1'b0;
    step();
    check("wrap_cnt16", {16'b0, retire_cnt}, 32'd17);
    check("wrap_cnt4", {28'b0, retire_cnt2}, 32'd1);

    // reset mid-stream beats an accept
    drive(2'd0, 32'h77, 4'd3, 32'h700, 1'b1);
    step();
    check("mid_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_data", write_data, 32'd0);
    check("mid_rst_rd", {28'b0, rd_out}, 32'd0);
    check("mid_rst_pc", pc_out, 32'd0);
    check("mid_rst_rw", {31'b0, reg_write_out}, 32'd0);
    check("mid_rst_cnt", {16'b0, retire_cnt}, 32'd0);
    check("mid_rst_cnt4", {28'b0, retire_cnt2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
